// File: rtl/key_led_pkg.sv
// key_led_pkg: shared FSM state type and constants for the key/LED Avalon master.
package key_led_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;
    localparam int PIO_RD_LATENCY = 1;
    localparam int NUM_KEYS = 4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-key sample shift register; accepts a level after DEB_SAMPLES equal polls.
module key_debounce #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic fall_o
);
    logic [DEB_SAMPLES-1:0] sh_q, sh_d;
    logic state_q, press_q, stable, change;
    assign sh_d = {sh_q[DEB_SAMPLES-2:0], key_i};
    assign stable = &sh_d | ~|sh_d;
    assign change = sample_i && stable && (sh_d[0] != state_q);
    // fall_o lets the top toggle its LED on the same edge that the pulse is registered
    assign fall_o = change && !sh_d[0];
    assign state_o = state_q;
    assign press_o = press_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '1;
            state_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            press_q <= fall_o;
            if (sample_i) sh_q <= sh_d;
            if (change) state_q <= sh_d[0];
        end
    end
endmodule

// File: rtl/key_led_master.sv
// key_led_master: polls key PIO over Avalon-MM, debounces keys, toggles LEDs and writes the LED PIO.
module key_led_master
    import key_led_pkg::*;
#(
    parameter int                POLL_CYCLES = 50000,
    parameter int                DEB_SAMPLES = 4,
    parameter int                ADDR_W      = 4,
    parameter logic [ADDR_W-1:0] KEY_ADDR    = 'h0,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 'h8,
    parameter bit                LED_INVERT  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic [31:0]         avm_readdata,
    input  logic                avm_waitrequest,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] led_state,
    output logic                busy
);
    localparam int CW = $clog2(POLL_CYCLES);
    state_e state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] lat_q;
    logic poll_pend_q, poll_pend_d, wr_pend_q, wr_pend_d;
    logic tick, rd_ack, wr_ack, sample;
    logic [NUM_KEYS-1:0] led_q, fall;
    logic [31:0] wdata;
    logic unused_rd;
    assign unused_rd = ^avm_readdata[31:NUM_KEYS];
    assign tick = cnt_q == CW'(POLL_CYCLES - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign rd_ack = state_q == RD_REQ && !avm_waitrequest;
    assign wr_ack = state_q == WR_REQ && !avm_waitrequest;
    assign sample = state_q == RD_WAIT && lat_q == 2'd0;
    // a tick that finds poll_pend already set is simply absorbed
    assign poll_pend_d = tick | (poll_pend_q & ~rd_ack);
    assign wr_pend_d = |fall | (wr_pend_q & ~wr_ack);
    assign wdata = {{(32 - NUM_KEYS){1'b0}}, led_q ^ {NUM_KEYS{LED_INVERT}}};
    assign led_state = led_q;
    assign busy = state_q != IDLE;
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk(clk),
            .reset(reset),
            .sample_i(sample),
            .key_i(avm_readdata[i]),
            .state_o(key_state[i]),
            .press_o(key_press[i]),
            .fall_o(fall[i])
        );
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            poll_pend_q <= 1'b0;
            wr_pend_q   <= 1'b1;
            led_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            poll_pend_q <= poll_pend_d;
            wr_pend_q   <= wr_pend_d;
            led_q       <= led_q ^ fall;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            lat_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_pend_q) begin
                        state_q       <= WR_REQ;
                        avm_write     <= 1'b1;
                        avm_address   <= LED_ADDR;
                        avm_writedata <= wdata;
                    end else if (poll_pend_q) begin
                        state_q     <= RD_REQ;
                        avm_read    <= 1'b1;
                        avm_address <= KEY_ADDR;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        state_q  <= RD_WAIT;
                        avm_read <= 1'b0;
                        lat_q    <= 2'(PIO_RD_LATENCY - 1);
                    end
                end
                RD_WAIT: begin
                    if (lat_q == 2'd0) state_q <= IDLE;
                    else lat_q <= lat_q - 2'd1;
                end
                WR_REQ: begin
                    // a poll waiting behind the write starts right away, without an idle cycle
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        if (poll_pend_q) begin
                            state_q     <= RD_REQ;
                            avm_read    <= 1'b1;
                            avm_address <= KEY_ADDR;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_led_master.sv
// tb_key_led_master: directed stimulus with a write/press scoreboard checked by a bus monitor.
module tb_key_led_master;
    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avm_address;
    logic        avm_read, avm_write, avm_waitrequest, busy;
    logic [31:0] avm_writedata, avm_readdata;
    logic [3:0]  key_state, key_press, led_state;
    logic [3:0]  key_val = 4'hF;
    logic        stall_rd = 1'b0;
    logic        stall_wr = 1'b0;
    int          checks = 0;
    int          passes = 0;
    int          rd_cnt = 0;
    wr_t         exp_wr[$];
    logic [3:0]  exp_press[$];

    assign avm_readdata = {28'b0, key_val};
    assign avm_waitrequest = (stall_rd & avm_read) | (stall_wr & avm_write);

    key_led_master #(.POLL_CYCLES(16), .DEB_SAMPLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .key_state(key_state),
        .key_press(key_press),
        .led_state(led_state),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel 0: read accepted this cycle, 1: read asserted, 2: write asserted
    task automatic wait_sig(input int sel, input int lim, input string name);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            cyc(1);
            n++;
            hit = sel == 0 ? (avm_read && !avm_waitrequest) : sel == 1 ? avm_read : avm_write;
        end
        chk(name, hit, 1);
    endtask

    // bus monitor: pops expected writes and presses as the DUT presents them
    initial begin
        logic        pv;
        logic [40:0] prev;
        wr_t         e;
        logic [3:0]  p;
        pv = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv) chk("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev);
                if (avm_write && !avm_waitrequest) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        $display("FAIL wr_unexpected: got write data %0h expected no write", avm_writedata);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", avm_address, e.addr);
                        chk("wr_data", avm_writedata, e.data);
                        chk("wr_busy", busy, 1);
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    rd_cnt++;
                    chk("rd_addr", avm_address, 4'h0);
                end
                if (key_press != 4'h0) begin
                    if (exp_press.size() == 0) begin
                        checks++;
                        $display("FAIL press_unexpected: got %0h expected no press", key_press);
                    end else begin
                        p = exp_press.pop_front();
                        chk("key_press", key_press, p);
                    end
                end
                pv = (avm_read || avm_write) && avm_waitrequest;
                prev = {avm_read, avm_write, avm_address, avm_writedata};
            end
        end
    end

    initial begin
        int base;
        // reset state
        cyc(3);
        chk("rst_bus", {avm_read, avm_write, avm_address, avm_writedata}, 0);
        chk("rst_press_busy", {key_press, busy}, 0);
        chk("rst_led", led_state, 4'h0);
        chk("rst_key_state", key_state, 4'hF);
        exp_wr.push_back('{addr: 4'h8, data: 32'h0000000F});
        rd_cnt = 0;
        reset = 1'b0;
        cyc(40);
        chk("poll_reads", rd_cnt, 2);
        // key0 press
        key_val = 4'hE;
        exp_press.push_back(4'b0001);
        exp_wr.push_back('{addr: 4'h8, data: 32'h0000000E});
        cyc(100);
        chk("k0_led", led_state, 4'h1);
        chk("k0_key_state", key_state, 4'hE);
        key_val = 4'hF;
        cyc(100);
        chk("k0_release", key_state, 4'hF);
        // key1 bounce on alternate polls
        for (int i = 0; i < 8; i++) begin
            wait_sig(0, 60, "bounce_read");
            cyc(2);
            key_val = i[0] ? 4'hF : 4'hD;
        end
        cyc(20);
        chk("bounce_key_state", key_state, 4'hF);
        chk("bounce_led", led_state, 4'h1);
        // stalled read
        wait_sig(0, 60, "pre_stall_read");
        cyc(1);
        stall_rd = 1'b1;
        wait_sig(1, 60, "stall_read_req");
        base = rd_cnt;
        cyc(5);
        chk("stall_read_held", {avm_read, avm_address}, {1'b1, 4'h0});
        stall_rd = 1'b0;
        cyc(2);
        chk("stall_read_done", rd_cnt, base + 1);
        base = rd_cnt;
        cyc(5);
        chk("no_extra_read", rd_cnt, base);
        // keys 2 and 3 together, write held in flight
        stall_wr = 1'b1;
        key_val = 4'h3;
        exp_press.push_back(4'b1100);
        exp_wr.push_back('{addr: 4'h8, data: 32'h00000002});
        wait_sig(2, 200, "k23_write");
        cyc(4);
        chk("k23_wdata_held", avm_writedata, 32'h2);
        stall_wr = 1'b0;
        cyc(3);
        chk("k23_led", led_state, 4'hD);
        key_val = 4'hF;
        cyc(100);
        chk("k23_release", key_state, 4'hF);
        // reset during WR_REQ
        stall_wr = 1'b1;
        key_val = 4'hD;
        exp_press.push_back(4'b0010);
        wait_sig(2, 200, "k1_write");
        cyc(1);
        chk("k1_led", led_state, 4'hF);
        reset = 1'b1;
        cyc(1);
        chk("abort_write", avm_write, 1'b0);
        chk("abort_led", led_state, 4'h0);
        chk("abort_key_state", key_state, 4'hF);
        key_val = 4'hF;
        stall_wr = 1'b0;
        exp_wr.push_back('{addr: 4'h8, data: 32'h0000000F});
        cyc(2);
        reset = 1'b0;
        cyc(40);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("press_queue_empty", exp_press.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
